// File: rtl/fpu_ss_issue_gate.sv
// Issue gate between the core offload port and the fpu_ss C-request channel.
// Registers each accepted instruction for one cycle, tracks issued-but-unanswered
// instructions in an in-order pending table, and stalls any new instruction whose
// integer rs1 will be written back by a pending FP instruction.

package acc_pkg;
    parameter int AddrWidth = 32;
endpackage

module fpu_ss_issue_gate #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = acc_pkg::AddrWidth,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_q_valid_i,
    output logic                  core_q_ready_o,
    input  logic [ADDR_WIDTH-1:0] core_q_addr_i,
    input  logic [2:0][31:0]      core_q_rs_i,
    input  logic [31:0]           core_q_instr_data_i,
    input  logic [31:0]           core_q_hart_id_i,
    output logic                  c_q_valid_o,
    input  logic                  c_q_ready_i,
    output logic [ADDR_WIDTH-1:0] c_q_addr_o,
    output logic [2:0][31:0]      c_q_rs_o,
    output logic [31:0]           c_q_instr_data_o,
    output logic [31:0]           c_q_hart_id_o,
    input  logic                  c_p_valid_i,
    input  logic                  c_p_ready_i,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic       valid;
        logic       int_wb;
        logic [4:0] rd;
    } pend_t;

    pend_t              tbl [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               new_int_wb;
    logic               new_reads_rs1;
    logic               rd_hit;
    logic               hazard;
    logic               accept;
    logic               resp_hs;
    logic               retire;

    // Instruction returns an integer result (FCMP/FCLASS/FMV.X.W/FCVT.W or CSR access).
    function automatic logic is_int_wb(input logic [31:0] instr);
        logic [6:0] op;
        logic [4:0] f5;
        logic [2:0] f3;
        op = instr[6:0];
        f5 = instr[31:27];
        f3 = instr[14:12];
        return ((op == 7'b1010011) && (f5 == 5'b11100 || f5 == 5'b10100 || f5 == 5'b11000))
            || ((op == 7'b1110011) && (f3 != 3'b000));
    endfunction

    // Instruction consumes integer rs1 (FP load/store, int->FP moves/converts, CSR reg forms).
    function automatic logic is_reads_rs1(input logic [31:0] instr);
        logic [6:0] op;
        logic [4:0] f5;
        logic [2:0] f3;
        op = instr[6:0];
        f5 = instr[31:27];
        f3 = instr[14:12];
        return (op == 7'b0000111) || (op == 7'b0100111)
            || ((op == 7'b1010011) && (f5 == 5'b11010 || f5 == 5'b11110))
            || ((op == 7'b1110011) && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011));
    endfunction

    // Hazard search of the new instruction's rs1 against every pending integer writer.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it
        // holding its old value and no latch is inferred.
        rd_hit        = 1'b0;
        new_int_wb    = is_int_wb(core_q_instr_data_i);
        new_reads_rs1 = is_reads_rs1(core_q_instr_data_i);
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (tbl[i].valid && tbl[i].int_wb && (tbl[i].rd != 5'd0)
                && (tbl[i].rd == core_q_instr_data_i[19:15])) begin
                rd_hit = 1'b1;
            end
        end
        hazard = new_reads_rs1 & rd_hit;
    end

    assign core_q_ready_o = ~hazard
                          & (outstanding_o < CNT_W'(MAX_OUTSTANDING))
                          & (~c_q_valid_o | c_q_ready_i);
    assign accept  = core_q_valid_i & core_q_ready_o;
    assign resp_hs = c_p_valid_i & c_p_ready_i;
    assign retire  = resp_hs & (outstanding_o != '0);

    // Output register, pending table, pointers, outstanding count and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the pending table is only a handful of flops and its valid bits gate
            // the hazard search, so it is cleared on reset rather than left as memory.
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tbl[i] <= '0;
            end
            c_q_valid_o      <= 1'b0;
            c_q_addr_o       <= '0;
            c_q_rs_o         <= '0;
            c_q_instr_data_o <= '0;
            c_q_hart_id_o    <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            outstanding_o    <= '0;
            err_o            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here sees the
            // pre-edge values regardless of statement order.
            if (accept) begin
                c_q_valid_o      <= 1'b1;
                c_q_addr_o       <= core_q_addr_i;
                c_q_rs_o         <= core_q_rs_i;
                c_q_instr_data_o <= core_q_instr_data_i;
                c_q_hart_id_o    <= core_q_hart_id_i;
            end else if (c_q_ready_i) begin
                c_q_valid_o      <= 1'b0;
            end

            // Table is never full and empty at once, so retire and accept hit distinct slots.
            if (retire) begin
                tbl[rd_ptr].valid <= 1'b0;
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (accept) begin
                tbl[wr_ptr] <= '{valid: 1'b1, int_wb: new_int_wb, rd: core_q_instr_data_i[11:7]};
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end

            case ({accept, retire})
                2'b10:   outstanding_o <= outstanding_o + 1'b1;
                2'b01:   outstanding_o <= outstanding_o - 1'b1;
                default: outstanding_o <= outstanding_o;
            endcase

            if (resp_hs && (outstanding_o == '0)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_ss_issue_gate.sv
// Scoreboard bench for fpu_ss_issue_gate: directed scenarios followed by random traffic,
// checked against a queue-based model of the pending instructions.

module tb_fpu_ss_issue_gate;

    localparam int MAX_OUT = 4;
    localparam int AW      = acc_pkg::AddrWidth;
    localparam int CW      = $clog2(MAX_OUT + 1);

    localparam logic [31:0] FADD  = 32'h0020_8053;
    localparam logic [31:0] FEQ5  = 32'hA0A1_A2D3;
    localparam logic [31:0] FLW5  = 32'h0002_A087;
    localparam logic [31:0] FEQ0  = 32'hA0A1_A053;
    localparam logic [31:0] FLW0  = 32'h0000_2087;
    localparam logic [31:0] FADD2 = 32'h0031_01D3;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                core_q_valid_i;
    logic                core_q_ready_o;
    logic [AW-1:0]       core_q_addr_i;
    logic [2:0][31:0]    core_q_rs_i;
    logic [31:0]         core_q_instr_data_i;
    logic [31:0]         core_q_hart_id_i;
    logic                c_q_valid_o;
    logic                c_q_ready_i;
    logic [AW-1:0]       c_q_addr_o;
    logic [2:0][31:0]    c_q_rs_o;
    logic [31:0]         c_q_instr_data_o;
    logic [31:0]         c_q_hart_id_o;
    logic                c_p_valid_i;
    logic                c_p_ready_i;
    logic [CW-1:0]       outstanding_o;
    logic                err_o;

    fpu_ss_issue_gate #(.MAX_OUTSTANDING(MAX_OUT), .ADDR_WIDTH(AW)) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .core_q_valid_i      (core_q_valid_i),
        .core_q_ready_o      (core_q_ready_o),
        .core_q_addr_i       (core_q_addr_i),
        .core_q_rs_i         (core_q_rs_i),
        .core_q_instr_data_i (core_q_instr_data_i),
        .core_q_hart_id_i    (core_q_hart_id_i),
        .c_q_valid_o         (c_q_valid_o),
        .c_q_ready_i         (c_q_ready_i),
        .c_q_addr_o          (c_q_addr_o),
        .c_q_rs_o            (c_q_rs_o),
        .c_q_instr_data_o    (c_q_instr_data_o),
        .c_q_hart_id_o       (c_q_hart_id_o),
        .c_p_valid_i         (c_p_valid_i),
        .c_p_ready_i         (c_p_ready_i),
        .outstanding_o       (outstanding_o),
        .err_o               (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [2:0][31:0] rs;
        logic [31:0]      instr;
        logic [31:0]      hart;
    } pay_t;

    typedef struct {
        logic       int_wb;
        logic [4:0] rd;
    } pend_t;

    pay_t  exp_q[$];   // accepted, not yet handed to fpu_ss
    pend_t pend[$];    // accepted, not yet answered (oldest first)
    logic  exp_err;
    logic  last_ready;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference classification, written straight from the instruction encodings.
    function automatic logic m_int_wb(input logic [31:0] ins);
        case (ins[6:0])
            7'b1010011: return ins[31:27] inside {5'b11100, 5'b10100, 5'b11000};
            7'b1110011: return ins[14:12] != 3'b000;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic m_reads_rs1(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000111, 7'b0100111: return 1'b1;
            7'b1010011: return ins[31:27] inside {5'b11010, 5'b11110};
            7'b1110011: return ins[14:12] inside {3'b001, 3'b010, 3'b011};
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic m_ready(input logic [31:0] ins, input logic cqr);
        logic haz;
        haz = 1'b0;
        if (m_reads_rs1(ins))
            foreach (pend[i])
                if (pend[i].int_wb && pend[i].rd != 5'd0 && pend[i].rd == ins[19:15]) haz = 1'b1;
        return !haz && (pend.size() < MAX_OUT) && (exp_q.size() == 0 || cqr);
    endfunction

    // One clock of stimulus: check state, drive, check ready, then advance the model.
    task automatic step(input logic v, input logic [31:0] ins, input logic cqr,
                        input logic pv, input logic pr, input logic rst);
        logic exp_rdy, acc;
        pay_t p;
        @(negedge clk);
        check("outstanding", outstanding_o, pend.size());
        check("err", err_o, exp_err);
        rst_i               = rst;
        core_q_valid_i      = v;
        core_q_instr_data_i = ins;
        core_q_addr_i       = AW'($urandom);
        core_q_rs_i         = {$urandom, $urandom, $urandom};
        core_q_hart_id_i    = $urandom;
        c_q_ready_i         = cqr;
        c_p_valid_i         = pv;
        c_p_ready_i         = pr;
        #1;
        exp_rdy = m_ready(ins, cqr);
        check("core_q_ready", core_q_ready_o, exp_rdy);
        last_ready = core_q_ready_o;
        acc = v && exp_rdy && !rst;
        p = '{addr: core_q_addr_i, rs: core_q_rs_i, instr: ins, hart: core_q_hart_id_i};
        @(posedge clk);
        #1;
        if (rst) begin
            pend.delete();
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            if (pv && pr) begin
                if (pend.size() == 0) exp_err = 1'b1;
                else void'(pend.pop_front());
            end
            if (acc) begin
                pend.push_back('{int_wb: m_int_wb(ins), rd: ins[11:7]});
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic idle(input logic pv);
        step(1'b0, 32'h0, 1'b1, pv, pv, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs1;
        logic [2:0] f3;
        logic [4:0] f5;
        logic [6:0] op;
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        f3  = 3'($urandom_range(0, 7));
        f5  = 5'b00000;
        op  = 7'b1010011;
        case ($urandom_range(0, 5))
            0: begin
                case ($urandom_range(0, 2))
                    0: f5 = 5'b11100;
                    1: f5 = 5'b10100;
                    default: f5 = 5'b11000;
                endcase
            end
            1: f5 = ($urandom_range(0, 1) == 0) ? 5'b11010 : 5'b11110;
            2: op = 7'b1110011;
            3: op = ($urandom_range(0, 1) == 0) ? 7'b0000111 : 7'b0100111;
            4: f5 = 5'b00000;
            default: return $urandom;
        endcase
        return {f5, 2'b00, 5'd2, rs1, f3, rd, op};
    endfunction

    // Monitor: c_q_valid_o must match the model, payload must match while valid,
    // and the oldest expected payload is consumed on each c_q handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("c_q_valid", c_q_valid_o, exp_q.size() != 0);
            if (exp_q.size() != 0 && c_q_valid_o) begin
                check("c_q_addr",  c_q_addr_o,       exp_q[0].addr);
                check("c_q_rs",    c_q_rs_o,         exp_q[0].rs);
                check("c_q_instr", c_q_instr_data_o, exp_q[0].instr);
                check("c_q_hart",  c_q_hart_id_o,    exp_q[0].hart);
                if (c_q_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_i = 1'b1; core_q_valid_i = 1'b0; core_q_addr_i = '0; core_q_rs_i = '0;
        core_q_instr_data_i = '0; core_q_hart_id_i = '0; c_q_ready_i = 1'b0;
        c_p_valid_i = 1'b0; c_p_ready_i = 1'b0; exp_err = 1'b0; last_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outstanding", outstanding_o, 0);
        check("rst_valid", c_q_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_payload", {c_q_addr_o, c_q_instr_data_o, c_q_hart_id_o}, 0);
        check("rst_payload_rs", c_q_rs_o, 0);

        // Single FADD: latency 1, counted outstanding, then retired.
        step(1, FADD, 1, 0, 0, 0);
        check("fadd_valid", c_q_valid_o, 1);
        check("fadd_instr", c_q_instr_data_o, FADD);
        check("fadd_outstanding", outstanding_o, 1);
        idle(0);
        idle(1);
        check("fadd_retired", outstanding_o, 0);

        // FEQ.S x5 then FLW via x5: stall until FEQ retires, no same-cycle bypass.
        step(1, FEQ5, 1, 0, 0, 0);
        step(1, FLW5, 1, 0, 0, 0);
        check("flw_stall", last_ready, 0);
        step(1, FLW5, 1, 0, 0, 0);
        step(1, FLW5, 1, 1, 1, 0);
        check("flw_no_bypass", last_ready, 0);
        step(1, FLW5, 1, 0, 0, 0);
        check("flw_after_retire", last_ready, 1);
        idle(0);
        idle(1);

        // Writer to x0 never stalls.
        step(1, FEQ0, 1, 0, 0, 0);
        step(1, FLW0, 1, 0, 0, 0);
        check("x0_no_stall", last_ready, 1);
        idle(1);
        idle(1);

        // Fill to MAX_OUTSTANDING, then retire+accept together and wrap pointers.
        repeat (MAX_OUT) step(1, FADD, 1, 0, 0, 0);
        check("full_count", outstanding_o, MAX_OUT);
        step(1, FADD, 1, 0, 0, 0);
        check("full_stall", last_ready, 0);
        idle(1);
        step(1, FADD2, 1, 1, 1, 0);
        check("acc_ret_same", outstanding_o, MAX_OUT - 1);
        step(1, FEQ5, 1, 0, 0, 0);
        check("refill", outstanding_o, MAX_OUT);
        repeat (MAX_OUT) idle(1);
        check("drained", outstanding_o, 0);

        // Back-pressure on c_q: payload held, no new accept, then handshake + accept.
        step(1, FADD, 1, 0, 0, 0);
        repeat (3) begin
            step(1, FADD2, 0, 0, 0, 0);
            check("bp_stall", last_ready, 0);
            check("bp_hold", c_q_instr_data_o, FADD);
        end
        step(1, FADD2, 1, 0, 0, 0);
        check("bp_release", last_ready, 1);
        check("bp_next", c_q_instr_data_o, FADD2);
        idle(1);
        idle(1);

        // Response with nothing outstanding: ignored, sticky error until reset.
        idle(1);
        check("err_count", outstanding_o, 0);
        check("err_set", err_o, 1);
        step(1, FADD, 1, 0, 0, 0);
        idle(0);
        check("err_sticky", err_o, 1);
        step(0, 32'h0, 1, 0, 0, 1);
        check("err_cleared", err_o, 0);
        check("rst_midflight", outstanding_o, 0);

        // Random traffic with occasional mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 249) == 0);
        end
        idle(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
